// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared definitions for the keypad emulator: key code values,
//                one-hot scanner column strobes, one-hot row masks and the
//                emulator state encoding.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package keypad_pkg;

   // Non-digit key codes; digits use their own value 0-9.
   localparam logic [3:0] KEY_STAR = 4'd10;
   localparam logic [3:0] KEY_HASH = 4'd11;

   // Scanner column strobes (one-hot, 000 while the scanner is idle).
   localparam logic [2:0] NO_SCAN  = 3'b000;
   localparam logic [2:0] COLUMN1  = 3'b001;   // 1 4 7 *
   localparam logic [2:0] COLUMN2  = 3'b010;   // 2 5 8 0
   localparam logic [2:0] COLUMN3  = 3'b100;   // 3 6 9 #

   // Row line masks (one-hot).
   localparam logic [3:0] ROW1     = 4'b0001;  // 1 2 3
   localparam logic [3:0] ROW2     = 4'b0010;  // 4 5 6
   localparam logic [3:0] ROW3     = 4'b0100;  // 7 8 9
   localparam logic [3:0] ROW4     = 4'b1000;  // * 0 #

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_COL = 2'd1,
      HOLD     = 2'd2,
      GAP      = 2'd3
   } emu_state_t;

endpackage : keypad_pkg
`default_nettype wire

// File: rtl/keypad_keymap.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_keymap
//  Description : Combinational key code -> matrix position lookup. This is the
//                exact inverse of the scanner's (column, row) -> key decode.
//  Ports       : code      in  4  key code (0-9, 10 '*', 11 '#')
//                col_mask  out 3  one-hot column the key sits on
//                row_mask  out 4  one-hot row the key sits on
//                valid     out 1  code is a real key (0-11)
//  Revision    : 1.0  initial release
// ============================================================================
module keypad_keymap
   import keypad_pkg::*;
(
   input  logic [3:0] code,
   output logic [2:0] col_mask,
   output logic [3:0] row_mask,
   output logic       valid
);

   always_comb begin
      col_mask = NO_SCAN;
      row_mask = 4'b0000;
      valid    = 1'b1;
      case (code)
         4'd1:     begin col_mask = COLUMN1; row_mask = ROW1; end
         4'd2:     begin col_mask = COLUMN2; row_mask = ROW1; end
         4'd3:     begin col_mask = COLUMN3; row_mask = ROW1; end
         4'd4:     begin col_mask = COLUMN1; row_mask = ROW2; end
         4'd5:     begin col_mask = COLUMN2; row_mask = ROW2; end
         4'd6:     begin col_mask = COLUMN3; row_mask = ROW2; end
         4'd7:     begin col_mask = COLUMN1; row_mask = ROW3; end
         4'd8:     begin col_mask = COLUMN2; row_mask = ROW3; end
         4'd9:     begin col_mask = COLUMN3; row_mask = ROW3; end
         KEY_STAR: begin col_mask = COLUMN1; row_mask = ROW4; end
         4'd0:     begin col_mask = COLUMN2; row_mask = ROW4; end
         KEY_HASH: begin col_mask = COLUMN3; row_mask = ROW4; end
         default:  valid = 1'b0;
      endcase
   end

endmodule : keypad_keymap
`default_nettype wire

// File: rtl/keypad_emu.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_emu
//  Description : Keypad matrix responder. Takes a key code, waits for the
//                scanner to strobe the key's column, then drives the key's
//                row for HOLD_CYCLES, forces a release gap of GAP_CYCLES and
//                reports done. Aborts with err on an invalid code or when the
//                column never shows up within TIMEOUT_CYCLES.
//  Ports       : clk         in  1  system clock
//                rst         in  1  asynchronous reset, active low
//                key_col     in  3  scanner column strobe (one-hot)
//                press_req   in  1  press request (level, sampled in IDLE)
//                press_code  in  4  key code to press
//                key_row     out 4  emulated row lines (one-hot or 0)
//                press_ack   out 1  pulse: request accepted
//                busy        out 1  any state other than IDLE
//                done        out 1  pulse: press and release gap finished
//                err         out 1  pulse: invalid code or column timeout
//  Revision    : 1.0  initial release
// ============================================================================
module keypad_emu
   import keypad_pkg::*;
#(
   parameter int HOLD_CYCLES    = 250000,
   parameter int GAP_CYCLES     = 250000,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int CNT_W          = 21
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] key_col,
   input  logic       press_req,
   input  logic [3:0] press_code,
   output logic [3:0] key_row,
   output logic       press_ack,
   output logic       busy,
   output logic       done,
   output logic       err
);

   // Terminal counts: phases end when the counter equals param-1, so the
   // counter never needs to wrap or saturate.
   localparam logic [CNT_W-1:0] C_HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

   emu_state_t       r_state,     w_state_nxt;
   logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
   logic [3:0]       r_code,      w_code_nxt;
   logic [3:0]       r_key_row,   w_key_row_nxt;
   logic             r_press_ack, w_press_ack_nxt;
   logic             r_done,      w_done_nxt;
   logic             r_err,       w_err_nxt;

   logic [3:0]       w_map_code;
   logic [2:0]       w_col_mask;
   logic [3:0]       w_row_mask;
   logic             w_valid;
   logic             w_col_hit;

   // One lookup serves both jobs: validating the incoming code while idle,
   // and locating the latched code once a press is under way.
   assign w_map_code = (r_state == IDLE) ? press_code : r_code;

   keypad_keymap u_keymap (
      .code     (w_map_code),
      .col_mask (w_col_mask),
      .row_mask (w_row_mask),
      .valid    (w_valid)
   );

   // The target column is one-hot, so a plain equality already rejects
   // multi-hot or idle strobes.
   assign w_col_hit = (key_col == w_col_mask);

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_code_nxt      = r_code;
      w_key_row_nxt   = 4'b0000;
      w_press_ack_nxt = 1'b0;
      w_done_nxt      = 1'b0;
      w_err_nxt       = 1'b0;

      case (r_state)
         IDLE: begin
            if (press_req) begin
               if (w_valid) begin
                  w_code_nxt      = press_code;
                  w_press_ack_nxt = 1'b1;
                  w_cnt_nxt       = '0;
                  w_state_nxt     = WAIT_COL;
               end else begin
                  w_err_nxt = 1'b1;
               end
            end
         end

         WAIT_COL: begin
            if (w_col_hit) begin
               w_key_row_nxt = w_row_mask;
               w_cnt_nxt     = '0;
               w_state_nxt   = HOLD;
            end else if (r_cnt == C_TIMEOUT_LAST) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt = r_cnt + C_CNT_ONE;
            end
         end

         HOLD: begin
            // Row follows the column strobe so it can never appear on a
            // foreign column, even if the scanner ignores the freeze.
            if (r_cnt == C_HOLD_LAST) begin
               w_cnt_nxt   = '0;
               w_state_nxt = GAP;
            end else begin
               w_cnt_nxt = r_cnt + C_CNT_ONE;
               if (w_col_hit) begin
                  w_key_row_nxt = w_row_mask;
               end
            end
         end

         GAP: begin
            if (r_cnt == C_GAP_LAST) begin
               w_done_nxt  = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt = r_cnt + C_CNT_ONE;
            end
         end

         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_code      <= 4'd0;
         r_key_row   <= 4'b0000;
         r_press_ack <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_code      <= w_code_nxt;
         r_key_row   <= w_key_row_nxt;
         r_press_ack <= w_press_ack_nxt;
         r_done      <= w_done_nxt;
         r_err       <= w_err_nxt;
      end
   end

   assign key_row   = r_key_row;
   assign press_ack = r_press_ack;
   assign done      = r_done;
   assign err       = r_err;
   assign busy      = (r_state != IDLE);

endmodule : keypad_emu
`default_nettype wire

// File: tb/tb_keypad_emu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_emu
//  Description : Bench for keypad_emu with a column-cycling scanner model that
//                freezes its column while any row is driven. Expected events
//                are queued by the stimulus and checked by a monitor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_keypad_emu;

   localparam int HOLD_CYCLES    = 8;
   localparam int GAP_CYCLES     = 4;
   localparam int TIMEOUT_CYCLES = 20;

   localparam int EV_ACK   = 0;
   localparam int EV_ERR   = 1;
   localparam int EV_PRESS = 2;
   localparam int EV_DONE  = 3;

   typedef struct {
      int kind;
      int code;
      int val;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] key_col = 3'b001;
   logic       press_req = 1'b0;
   logic [3:0] press_code = 4'd0;
   logic [3:0] key_row;
   logic       press_ack;
   logic       busy;
   logic       done;
   logic       err;

   logic       force_en = 1'b0;
   logic [2:0] force_col = 3'b000;
   int         scan_idx = 0;

   int   checks = 0;
   int   errors = 0;
   ev_t  exp_q[$];

   int   cur_code = -1;
   int   hold_len = 0;
   int   seen_code = -1;
   int   since_ack = 0;
   int   since_done = 0;
   int   since_fall = 0;
   logic [3:0] prev_row = 4'b0000;

   keypad_emu #(
      .HOLD_CYCLES    (HOLD_CYCLES),
      .GAP_CYCLES     (GAP_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (21)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .key_col    (key_col),
      .press_req  (press_req),
      .press_code (press_code),
      .key_row    (key_row),
      .press_ack  (press_ack),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Scanner model: steps 001 -> 010 -> 100 -> 000 each cycle, frozen while a
   // row is high; force_en overrides the strobe entirely.
   always @(posedge clk) begin
      #1;
      if (force_en) begin
         key_col = force_col;
      end else if (key_row == 4'b0000) begin
         scan_idx = (scan_idx + 1) % 4;
         case (scan_idx)
            0:       key_col = 3'b001;
            1:       key_col = 3'b010;
            2:       key_col = 3'b100;
            default: key_col = 3'b000;
         endcase
      end
   end

   // Reference keypad decode: (column, row) -> key code, -1 when not a key.
   function automatic int decode(input logic [2:0] col, input logic [3:0] row);
      int c;
      int r;
      case (col)
         3'b001:  c = 0;
         3'b010:  c = 1;
         3'b100:  c = 2;
         default: c = -1;
      endcase
      case (row)
         4'b0001: r = 0;
         4'b0010: r = 1;
         4'b0100: r = 2;
         4'b1000: r = 3;
         default: r = -1;
      endcase
      if (c < 0 || r < 0) return -1;
      if (r < 3) return r * 3 + c + 1;
      if (c == 0) return 10;
      if (c == 1) return 0;
      return 11;
   endfunction

   function automatic string kname(input int k);
      case (k)
         EV_ACK:   return "ack";
         EV_ERR:   return "err";
         EV_PRESS: return "press";
         default:  return "done";
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic push(input int kind, input int code, input int val);
      ev_t e;
      e.kind = kind;
      e.code = code;
      e.val  = val;
      exp_q.push_back(e);
   endtask

   // Pops the next expected event and checks that it is of the given kind.
   task automatic pop_ev(input int kind, output ev_t e, output bit ok);
      ok = 1'b0;
      e.kind = -1;
      e.code = -1;
      e.val  = -1;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_%s: got event with empty expectation queue (t=%0t)", kname(kind), $time);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind) begin
            errors++;
            $display("FAIL event_order: got %s expected %s (t=%0t)", kname(kind), kname(e.kind), $time);
         end else begin
            ok = 1'b1;
         end
      end
   endtask

   task automatic mon_step();
      ev_t e;
      bit  ok;
      int  k;
      if (!rst) begin
         prev_row = 4'b0000;
         hold_len = 0;
         return;
      end
      since_ack++;
      since_done++;
      since_fall++;

      if (key_row != 4'b0000) begin
         k = decode(key_col, key_row);
         chk("row_key_match", k, cur_code);
         chk("row_while_busy", int'(busy), 1);
         if (prev_row == 4'b0000) begin
            hold_len  = 1;
            seen_code = k;
         end else begin
            hold_len++;
         end
      end else if (prev_row != 4'b0000) begin
         since_fall = 0;
         pop_ev(EV_PRESS, e, ok);
         if (ok) begin
            chk("press_key", seen_code, e.code);
            chk("hold_len", hold_len, e.val);
         end
      end

      if (press_ack) begin
         pop_ev(EV_ACK, e, ok);
         if (ok) begin
            cur_code = e.code;
            if (e.val >= 0) chk("ack_after_done", since_done, e.val);
         end
         since_ack = 0;
      end
      if (err) begin
         pop_ev(EV_ERR, e, ok);
         if (ok && e.val >= 0) chk("timeout_len", since_ack, e.val);
      end
      if (done) begin
         pop_ev(EV_DONE, e, ok);
         if (ok) chk("gap_len", since_fall, e.val);
         since_done = 0;
      end
      prev_row = key_row;
   endtask

   task automatic request(input int code);
      press_code = 4'(code);
      press_req  = 1'b1;
      @(posedge clk); #1;
      press_req  = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk(name, int'(busy), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic press_normal(input int code);
      push(EV_ACK, code, -1);
      push(EV_PRESS, code, HOLD_CYCLES);
      push(EV_DONE, code, GAP_CYCLES);
      request(code);
      wait_idle("press_finish");
   endtask

   initial begin
      int n;
      // Reset state
      #12;
      chk("rst_key_row", int'(key_row), 0);
      chk("rst_ack", int'(press_ack), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      fork
         forever begin
            @(negedge clk);
            mon_step();
         end
         begin
            // 1: digit 5
            press_normal(5);

            // 2: '#' then '*'
            press_normal(11);
            press_normal(10);

            // 3: invalid code
            push(EV_ERR, 13, -1);
            request(13);
            chk("inv_err_pulse", int'(err), 1);
            chk("inv_no_ack", int'(press_ack), 0);
            chk("inv_busy", int'(busy), 0);
            chk("inv_row", int'(key_row), 0);
            repeat (3) @(posedge clk);
            #1;

            // 4: column never arrives
            force_en  = 1'b1;
            force_col = 3'b010;
            @(posedge clk); #1;
            push(EV_ACK, 7, -1);
            push(EV_ERR, 7, TIMEOUT_CYCLES);
            request(7);
            wait_idle("timeout_finish");
            force_en = 1'b0;

            // 5: reset during HOLD
            push(EV_ACK, 1, -1);
            request(1);
            n = 0;
            while (key_row == 4'b0000 && n < 40) begin
               @(posedge clk); #1;
               n++;
            end
            chk("rst_mid_row_seen", int'(key_row != 4'b0000), 1);
            repeat (3) @(posedge clk);
            #2;
            rst = 1'b0;
            #1;
            chk("rst_mid_row", int'(key_row), 0);
            chk("rst_mid_busy", int'(busy), 0);
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b1;
            repeat (30) @(posedge clk);
            #1;
            chk("rst_after_busy", int'(busy), 0);
            press_normal(3);

            // 6: back-to-back presses with press_req held high
            push(EV_ACK, 2, -1);
            push(EV_PRESS, 2, HOLD_CYCLES);
            push(EV_DONE, 2, GAP_CYCLES);
            push(EV_ACK, 9, 1);
            push(EV_PRESS, 9, HOLD_CYCLES);
            push(EV_DONE, 9, GAP_CYCLES);
            press_code = 4'd2;
            press_req  = 1'b1;
            n = 0;
            while (!press_ack && n < 5) begin
               @(posedge clk); #1;
               n++;
            end
            chk("b2b_first_ack", int'(press_ack), 1);
            press_code = 4'd9;
            repeat (2) @(posedge clk);
            #1;
            press_req = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            press_req = 1'b1;
            n = 0;
            while (!done && n < 100) begin
               @(posedge clk); #1;
               n++;
            end
            chk("b2b_first_done", int'(done), 1);
            @(posedge clk); #1;
            chk("b2b_second_ack", int'(press_ack), 1);
            press_req = 1'b0;
            wait_idle("b2b_finish");

            repeat (3) @(posedge clk);
            #1;
            chk("queue_empty", exp_q.size(), 0);
         end
      join_any

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_keypad_emu
`default_nettype wire
